// File: rtl/lfsr_encrypter.sv
// lfsr_encrypter: frames a plaintext message with pad bytes, XORs every byte with a 5-bit
// LFSR stream and writes the 64-byte ciphertext block. Optional macro: ENC_PARITY_EN.

module lfsr_encrypter #(
    parameter int unsigned SRC_BASE  = 0,
    parameter int unsigned DST_BASE  = 128,
    parameter int unsigned FRAME_LEN = 64,
    parameter logic [7:0]  PAD_CHAR  = 8'h7E,
    parameter int unsigned MAX_MSG   = 50
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       start,
    input  logic [7:0] pre_length,
    input  logic [2:0] pat_sel,
    input  logic [4:0] lfsr_init,
    input  logic [5:0] msg_len,
    output logic [7:0] mem_raddr,
    input  logic [7:0] mem_rdata,
    output logic       mem_wr_en,
    output logic [7:0] mem_waddr,
    output logic [7:0] mem_wdata,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_FETCH,
        S_EMIT,
        S_DONE
    } state_t;

    state_t     state;
    logic [6:0] idx;
    logic [6:0] idx_nx;
    logic [6:0] pre_q;
    logic [6:0] len_q;
    logic [4:0] taps_q;
    logic [4:0] lfsr;
    logic       in_win;

    logic [6:0] pre_c;
    logic [6:0] len_c;
    logic [4:0] taps_c;
    logic [4:0] seed_c;
    logic [7:0] plain;
    logic [7:0] cipher;

    function automatic logic in_window(input logic [6:0] k);
        return (k >= pre_q) && (k < (pre_q + len_q));
    endfunction

    function automatic logic [7:0] src_addr(input logic [6:0] k);
        return 8'(SRC_BASE) + {1'b0, k} - {1'b0, pre_q};
    endfunction

    always_comb begin
        if (pre_length < 8'd7)
            pre_c = 7'd7;
        else if (pre_length > 8'd12)
            pre_c = 7'd12;
        else
            pre_c = pre_length[6:0];

        if ({1'b0, msg_len} > 7'(MAX_MSG))
            len_c = 7'(MAX_MSG);
        else
            len_c = {1'b0, msg_len};

        case (pat_sel)
            3'd0:    taps_c = 5'h1E;
            3'd1:    taps_c = 5'h1D;
            3'd2:    taps_c = 5'h1B;
            3'd3:    taps_c = 5'h17;
            3'd4:    taps_c = 5'h14;
            3'd5:    taps_c = 5'h12;
            default: taps_c = 5'h17;
        endcase

        seed_c = (lfsr_init == 5'h00) ? 5'h01 : lfsr_init;
    end

    assign idx_nx = idx + 7'd1;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_raddr <= '0;
            mem_waddr <= '0;
            lfsr      <= 5'h01;
            idx       <= '0;
            pre_q     <= 7'd7;
            len_q     <= '0;
            taps_q    <= 5'h17;
            in_win    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state  <= S_SETUP;
                        pre_q  <= pre_c;
                        len_q  <= len_c;
                        taps_q <= taps_c;
                        lfsr   <= seed_c;
                        idx    <= '0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
                // Byte k's read address is issued on the edge entering its FETCH, so the
                // one-cycle synchronous read returns its data during the matching EMIT.
                S_SETUP: begin
                    state <= S_FETCH;
                    if (in_window('0))
                        mem_raddr <= src_addr('0);
                end
                S_FETCH: begin
                    state     <= S_EMIT;
                    mem_wr_en <= 1'b1;
                    mem_waddr <= 8'(DST_BASE) + {1'b0, idx};
                    in_win    <= in_window(idx);
                end
                S_EMIT: begin
                    mem_wr_en <= 1'b0;
                    lfsr      <= {lfsr[3:0], ^(lfsr & taps_q)};
                    idx       <= idx_nx;
                    if (idx == 7'(FRAME_LEN - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                        if (in_window(idx_nx))
                            mem_raddr <= src_addr(idx_nx);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    mem_wr_en <= 1'b0;
                end
            endcase
        end
    end

    // Cipher byte is formed from the read data arriving in EMIT; held at zero between writes.
    always_comb begin
        plain  = in_win ? mem_rdata : PAD_CHAR;
        cipher = plain ^ {3'b000, lfsr};
`ifdef ENC_PARITY_EN
        cipher[7] = ^cipher[6:0];
`endif
        mem_wdata = mem_wr_en ? cipher : '0;
    end

endmodule

// File: tb/tb_lfsr_encrypter.sv
// tb_lfsr_encrypter: directed-vector bench for lfsr_encrypter with a behavioural memory
// and an independent frame model.

module tb_lfsr_encrypter;

    logic       clk = 1'b0;
    logic       init_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pre_length = '0;
    logic [2:0] pat_sel = '0;
    logic [4:0] lfsr_init = '0;
    logic [5:0] msg_len = '0;
    logic [7:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;

    logic [7:0] src [128];
    logic [7:0] dst [64];
    logic [7:0] exp_frame [64];
    logic [7:0] saved [64];
    int         log_cyc [64];
    logic [7:0] log_addr [64];
    int         wr_cnt = 0;
    int         cyc = 0;
    int         t0 = 0;
    logic       clr_req = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         de;

    lfsr_encrypter #(
        .SRC_BASE (0),
        .DST_BASE (128),
        .FRAME_LEN(64),
        .PAD_CHAR (8'h7E),
        .MAX_MSG  (50)
    ) dut (
        .clk       (clk),
        .init_n    (init_n),
        .start     (start),
        .pre_length(pre_length),
        .pat_sel   (pat_sel),
        .lfsr_init (lfsr_init),
        .msg_len   (msg_len),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        mem_rdata <= (mem_raddr < 8'd128) ? src[mem_raddr[6:0]] : 8'h00;
        if (clr_req) begin
            for (int k = 0; k < 64; k++) dst[k] <= 8'h00;
            wr_cnt <= 0;
        end else if (mem_wr_en) begin
            if (wr_cnt < 64) begin
                log_cyc[wr_cnt]  <= cyc;
                log_addr[wr_cnt] <= mem_waddr;
            end
            if (mem_waddr >= 8'd128 && mem_waddr < 8'd192)
                dst[mem_waddr - 8'd128] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] taps_of(input logic [2:0] p);
        case (p)
            3'd0:    return 5'h1E;
            3'd1:    return 5'h1D;
            3'd2:    return 5'h1B;
            3'd3:    return 5'h17;
            3'd4:    return 5'h14;
            3'd5:    return 5'h12;
            default: return 5'h17;
        endcase
    endfunction

    task automatic build_exp(input int pre_raw, input logic [2:0] pat, input logic [4:0] seed,
                             input int len_raw);
        int         pre;
        int         len;
        logic [4:0] l;
        logic [4:0] t;
        logic [7:0] p;
        logic [7:0] b;
        pre = (pre_raw < 7) ? 7 : (pre_raw > 12) ? 12 : pre_raw;
        len = (len_raw > 50) ? 50 : len_raw;
        l   = (seed == 5'h00) ? 5'h01 : seed;
        t   = taps_of(pat);
        for (int i = 0; i < 64; i++) begin
            p = (i >= pre && i < pre + len) ? src[i - pre] : 8'h7E;
            b = p ^ {3'b000, l};
`ifdef ENC_PARITY_EN
            b[7] = ^b[6:0];
`endif
            exp_frame[i] = b;
            l = {l[3:0], ^(l & t)};
        end
    endtask

    task automatic clear_dst();
        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk);
        #1 clr_req = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] pre, input logic [2:0] pat, input logic [4:0] seed,
                             input logic [5:0] len, input bit poke40, output int done_edge);
        clear_dst();
        @(negedge clk);
        pre_length = pre;
        pat_sel    = pat;
        lfsr_init  = seed;
        msg_len    = len;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc;
        check_eq("busy after start", {31'b0, busy}, 32'd1);
        done_edge = -1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (poke40 && k == 39) begin
                start      = 1'b1;
                pre_length = 8'd12;
                pat_sel    = 3'd0;
                lfsr_init  = 5'h0F;
                msg_len    = 6'd3;
            end else if (k == 40) begin
                start = 1'b0;
            end
            if (done) begin
                done_edge = k;
                break;
            end
        end
        start = 1'b0;
        check_eq("done edge", done_edge, 32'd129);
        check_eq("busy at done", {31'b0, busy}, 32'd0);
    endtask

    task automatic check_frame(input string name);
        check_eq({name, " write count"}, wr_cnt, 32'd64);
        for (int i = 0; i < 64; i++) begin
            check_eq($sformatf("%s byte%0d", name, i), {24'b0, dst[i]}, {24'b0, exp_frame[i]});
            check_eq($sformatf("%s addr%0d", name, i), {24'b0, log_addr[i]}, 32'(128 + i));
            check_eq($sformatf("%s edge%0d", name, i), log_cyc[i] - t0, 32'(2 * i + 2));
        end
    endtask

    initial begin
        string msg;
        msg = "Mr_Watson_come_here";
        for (int a = 0; a < 128; a++) src[a] = 8'(a * 37 + 5);
        for (int k = 0; k < msg.len(); k++) src[k] = msg[k];

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst busy", {31'b0, busy}, 32'd0);
        check_eq("rst done", {31'b0, done}, 32'd0);
        check_eq("rst wr_en", {31'b0, mem_wr_en}, 32'd0);
        check_eq("rst raddr", {24'b0, mem_raddr}, 32'd0);
        check_eq("rst waddr", {24'b0, mem_waddr}, 32'd0);
        check_eq("rst wdata", {24'b0, mem_wdata}, 32'd0);
        @(negedge clk);
        init_n = 1'b1;

        // Case 1: reference message
        run_frame(8'd7, 3'd2, 5'h01, 6'd19, 1'b0, de);
`ifndef ENC_PARITY_EN
        check_eq("c1 byte128", {24'b0, dst[0]}, 32'h7F);
        check_eq("c1 byte129", {24'b0, dst[1]}, 32'h7D);
        check_eq("c1 byte130", {24'b0, dst[2]}, 32'h78);
        check_eq("c1 byte135", {24'b0, dst[7]}, 32'h59);
`else
        for (int i = 0; i < 64; i++)
            check_eq($sformatf("c1 parity%0d", i), {31'b0, dst[i][7]}, {31'b0, ^dst[i][6:0]});
`endif
        build_exp(7, 3'd2, 5'h01, 19);
        check_frame("c1");

        // Case 2: all configuration inputs out of range
        run_frame(8'd3, 3'd7, 5'h00, 6'd60, 1'b0, de);
        build_exp(3, 3'd7, 5'h00, 60);
        check_frame("c2");

        // Case 3: empty message, maximum preamble
        run_frame(8'd12, 3'd0, 5'h09, 6'd0, 1'b0, de);
        build_exp(12, 3'd0, 5'h09, 0);
        check_frame("c3");

        // Case 4: start during a run is ignored, then restart from DONE
        run_frame(8'd9, 3'd4, 5'h13, 6'd25, 1'b1, de);
        build_exp(9, 3'd4, 5'h13, 25);
        check_frame("c4a");
        for (int i = 0; i < 64; i++) saved[i] = dst[i];
        repeat (3) @(posedge clk);
        #1;
        check_eq("c4 done held", {31'b0, done}, 32'd1);
        run_frame(8'd9, 3'd4, 5'h13, 6'd25, 1'b0, de);
        check_frame("c4b");
        for (int i = 0; i < 64; i++)
            check_eq($sformatf("c4 rerun%0d", i), {24'b0, dst[i]}, {24'b0, saved[i]});

        // Case 5: reset in mid-run, then a clean run
        clear_dst();
        @(negedge clk);
        pre_length = 8'd8;
        pat_sel    = 3'd1;
        lfsr_init  = 5'h1F;
        msg_len    = 6'd30;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc;
        repeat (50) @(posedge clk);
        #1;
        check_eq("c5 wr_en before rst", {31'b0, mem_wr_en}, 32'd1);
        init_n = 1'b0;
        #1;
        check_eq("c5 wr_en in rst", {31'b0, mem_wr_en}, 32'd0);
        check_eq("c5 busy in rst", {31'b0, busy}, 32'd0);
        check_eq("c5 done in rst", {31'b0, done}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        build_exp(8, 3'd1, 5'h1F, 30);
        check_eq("c5 partial count", wr_cnt, 32'd24);
        check_eq("c5 byte23 kept", {24'b0, dst[23]}, {24'b0, exp_frame[23]});
        check_eq("c5 byte24 unwritten", {24'b0, dst[24]}, 32'd0);
        @(negedge clk);
        init_n = 1'b1;
        run_frame(8'd8, 3'd1, 5'h1F, 6'd30, 1'b0, de);
        check_frame("c5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
